// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load responses onto one regfile write port.
// Latency: selected write is registered onto wb_* one cycle after selection.
// Backpressure: ld_ready = !full from registered occupancy; alu_stall when loads have starved STARVE_MAX cycles.
// Optional feature: define WB_SCOREBOARD_EN to add the pend_mask output (registers with pending loads).
module wb_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         alu_valid,
  input  logic [4:0]                   alu_rd,
  input  logic [31:0]                  alu_data,
  output logic                         alu_stall,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [4:0]                   ld_rd,
  input  logic [31:0]                  ld_data,
  output logic                         wb_en,
  output logic [4:0]                   wb_addr,
  output logic [31:0]                  wb_data,
`ifdef WB_SCOREBOARD_EN
  output logic [31:0]                  pend_mask,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   ld_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX+1) : 1;

  // Load FIFO storage (not reset: validity is tracked by the occupancy count)
  logic [4:0]    rd_mem_q  [DEPTH];
  logic [31:0]   dat_mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          wb_en_q, wb_en_d;
  logic [4:0]    wb_addr_q, wb_addr_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic          empty, full, starved;
  logic          push, pop, alu_win;

  // Arbitration, FIFO pointer/occupancy and starvation next-state
  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == CW'(DEPTH));
    starved   = (starve_q == SW'(STARVE_MAX)) && !empty;
    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    ld_ready  = rstn && !full;
    // Loads to r0 are handshaken but never stored.
    push      = ld_valid && ld_ready && (ld_rd != 5'd0);
    alu_stall = alu_valid && starved;

    pop       = 1'b0;
    alu_win   = 1'b0;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    if (starved) begin
      pop = 1'b1;
    end else if (alu_valid && (alu_rd != 5'd0)) begin
      alu_win = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
    end

    if (pop) begin
      wb_en_d   = 1'b1;
      wb_addr_d = rd_mem_q[rptr_q];
      wb_data_d = dat_mem_q[rptr_q];
    end else if (alu_win) begin
      wb_en_d   = 1'b1;
      wb_addr_d = alu_rd;
      wb_data_d = alu_data;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    wptr_d = push ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d = pop  ? (rptr_q + PW'(1)) : rptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Only ALU wins over a waiting load count towards starvation.
    if (pop || empty) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // FIFO entry write on accepted non-r0 load
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]  <= ld_rd;
      dat_mem_q[wptr_q] <= ld_data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [PW-1:0] sb_off;

  // Mark every register targeted by a live FIFO entry; r0 is never pending
  always_comb begin
    pend_mask = '0;
    sb_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sb_off = PW'(i) - rptr_q;
      if (CW'(sb_off) < cnt_q) begin
        pend_mask[rd_mem_q[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end
`endif

  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign ld_count = cnt_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DEPTH=4, STARVE_MAX=3).
// Expected values are hand-derived per cycle.
// Inputs change 1 time unit after posedge; outputs sampled there as well.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  ld_count;
`ifdef WB_SCOREBOARD_EN
  logic [31:0] pend_mask;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
`ifdef WB_SCOREBOARD_EN
    .pend_mask (pend_mask),
`endif
    .ld_count  (ld_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h1;

    // Reset held two cycles with a load offered
    step(); step();
    chk("rst_wb_en", wb_en, 0);
    chk("rst_count", ld_count, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    rstn = 1'b1; ld_valid = 1'b0;
    #1;
    chk("rel_ld_ready", ld_ready, 1);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 chk("alu_no_stall", alu_stall, 0);
    step();
    chk("alu_en", wb_en, 1);
    chk("alu_addr", wb_addr, 5);
    chk("alu_data", wb_data, 32'hDEADBEEF);
    alu_rd = 5'd0; alu_data = 32'h1234;
    step();
    chk("alu_r0_en", wb_en, 0);
    chk("alu_r0_hold_addr", wb_addr, 5);
    chk("alu_r0_hold_data", wb_data, 32'hDEADBEEF);
    alu_valid = 1'b0;

    // Load to r0 is discarded
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    step();
    chk("ld_r0_count", ld_count, 0);
    chk("ld_r0_en", wb_en, 0);

    // Load fill without ALU: drained in order
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'h100 + i;
      step();
      if (i == 1) begin
        chk("fill_first_idle", wb_en, 0);
      end else begin
        chk("fill_addr", wb_addr, i - 1);
        chk("fill_data", wb_data, 32'h100 + i - 1);
      end
      chk("fill_count", ld_count, 1);
    end
    ld_valid = 1'b0;
    step();
    chk("fill_last_addr", wb_addr, 4);
    step();
    chk("fill_idle_en", wb_en, 0);
    chk("fill_empty", ld_count, 0);

    // Fill with ALU held: FIFO fills, starvation forces a pop, full blocks push
    alu_valid = 1'b1; alu_rd = 5'd7;
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'h100 + i; alu_data = 32'h7700 + i;
      step();
      chk("full_alu_addr", wb_addr, 7);
      chk("full_alu_data", wb_data, 32'h7700 + i);
      chk("full_count", ld_count, i);
    end
    chk("full_ld_ready", ld_ready, 0);
    ld_rd = 5'd5; ld_data = 32'h105;
    #1;
    chk("full_stall", alu_stall, 1);
    chk("full_no_ready", ld_ready, 0);
    step();
    chk("full_pop_addr", wb_addr, 1);
    chk("full_pop_data", wb_data, 32'h101);
    chk("full_pop_count", ld_count, 3);
    chk("after_pop_stall", alu_stall, 0);
    chk("after_pop_ready", ld_ready, 1);
    step();
    chk("late_push_alu", wb_addr, 7);
    chk("late_push_count", ld_count, 4);
    ld_valid = 1'b0; alu_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("drain_addr", wb_addr, k);
      chk("drain_data", wb_data, 32'h100 + k);
      chk("drain_count", ld_count, 5 - k);
    end

    // ALU to r0 leaves the slot to the FIFO
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h333;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
    step();
    chk("slot_no_write", wb_en, 0);
    ld_valid = 1'b0;
    #1 chk("slot_no_stall", alu_stall, 0);
    step();
    chk("slot_addr", wb_addr, 3);
    chk("slot_data", wb_data, 32'h333);

    // Starvation: one load, ALU every cycle
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h909;
    alu_rd = 5'd7; alu_data = 32'h7001;
    step();
    ld_valid = 1'b0;
    chk("starve_c1_addr", wb_addr, 7);
`ifdef WB_SCOREBOARD_EN
    chk("pend9_set", pend_mask[9], 1);
`endif
    for (int j = 2; j <= 4; j++) begin
      alu_data = 32'h7000 + j;
      #1 chk("starve_no_stall", alu_stall, 0);
      step();
      chk("starve_alu_addr", wb_addr, 7);
      chk("starve_alu_data", wb_data, 32'h7000 + j);
    end
    #1 chk("starve_stall", alu_stall, 1);
    step();
    chk("starve_ld_addr", wb_addr, 9);
    chk("starve_ld_data", wb_data, 32'h909);
    chk("starve_ld_count", ld_count, 0);
`ifdef WB_SCOREBOARD_EN
    chk("pend9_clear", pend_mask, 0);
`endif
    alu_data = 32'h7006;
    #1 chk("resume_no_stall", alu_stall, 0);
    step();
    chk("resume_addr", wb_addr, 7);
    chk("resume_data", wb_data, 32'h7006);
    alu_valid = 1'b0;

    // Two loads to the same register
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h991;
    step();
    ld_data = 32'h992;
    step();
    chk("dup_first_data", wb_data, 32'h991);
    chk("dup_count", ld_count, 1);
`ifdef WB_SCOREBOARD_EN
    chk("dup_pend_held", pend_mask[9], 1);
`endif
    ld_valid = 1'b0;
    step();
    chk("dup_second_data", wb_data, 32'h992);
    chk("dup_empty", ld_count, 0);
`ifdef WB_SCOREBOARD_EN
    chk("dup_pend_clear", pend_mask, 0);
`endif

    // Reset mid-operation discards buffered loads
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA;
    step();
    ld_rd = 5'd11; ld_data = 32'hB;
    step();
    chk("mid_count", ld_count, 2);
    rstn = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
    step();
    chk("mid_rst_count", ld_count, 0);
    chk("mid_rst_en", wb_en, 0);
    chk("mid_rst_addr", wb_addr, 0);
    rstn = 1'b1;
    step();
    chk("mid_after_en", wb_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
